// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared widths, FSM state type and grant helper for the mux8 round-robin arbiter.
package mux8_arb_pkg;
  localparam int N_REQ  = 8;
  localparam int SEL_W  = 3;
  localparam int DATA_W = 3;

  typedef enum logic {IDLE, BUSY} state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    return N_REQ'(1) << idx;
  endfunction
endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Request/data/output channel bundle between requesters and the arbiter.
interface mux8_rr_arbiter_if;
  import mux8_arb_pkg::*;

  logic [N_REQ-1:0]  req;
  logic [DATA_W-1:0] a, b, c, d, e, f, g, h;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [SEL_W-1:0]  sel;
  logic [N_REQ-1:0]  gnt;
  logic [N_REQ-1:0]  ack;
  logic              busy;

  modport slave (
    input  req, a, b, c, d, e, f, g, h, out_ready,
    output out_valid, out_data, sel, gnt, ack, busy
  );

  modport master (
    output req, a, b, c, d, e, f, g, h, out_ready,
    input  out_valid, out_data, sel, gnt, ack, busy
  );
endinterface

// File: rtl/mux8.sv
// Existing 8:1 datapath multiplexer, 3-bit words.
module mux8
  import mux8_arb_pkg::*;
(
  input  logic [DATA_W-1:0] a, b, c, d, e, f, g, h,
  input  logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] y
);
  always_comb begin
    case (sel)
      3'd0:    y = a;
      3'd1:    y = b;
      3'd2:    y = c;
      3'd3:    y = d;
      3'd4:    y = e;
      3'd5:    y = f;
      3'd6:    y = g;
      default: y = h;
    endcase
  end
endmodule

// File: rtl/mux8_rr_arbiter_rr_pick.sv
// Rotating-priority encoder: first set req bit at or after ptr, wrapping 7->0.
module rr_pick
  import mux8_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);
  // Scan farthest offset first so the nearest set bit is the last to win.
  always_comb begin
    any = 1'b0;
    idx = ptr;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[ptr + SEL_W'(i)]) begin
        any = 1'b1;
        idx = ptr + SEL_W'(i);
      end
    end
  end
endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing mux8 between eight requesters, BURST beats per grant.
//   state | meaning
//   IDLE  | no grant held, out_valid low, sel keeps last winner
//   BUSY  | one requester granted, its word presented on out_data
module mux8_rr_arbiter
  import mux8_arb_pkg::*;
#(
  parameter int BURST = 1,
  parameter int CNT_W = 4
) (
  input  logic          clk,
  input  logic          rst,
  mux8_rr_arbiter_if.slave bus
);
  localparam logic [CNT_W:0] BURST_C = (CNT_W + 1)'(BURST);

  state_t             state;
  logic [SEL_W-1:0]   ptr;
  logic [SEL_W-1:0]   sel_q;
  logic [N_REQ-1:0]   gnt_q;
  logic               valid_q;
  logic [CNT_W-1:0]   beat_cnt;
  logic [SEL_W-1:0]   pick_ptr;
  logic [SEL_W-1:0]   win;
  logic               any;
  logic               xfer;
  logic               keep;

  assign xfer     = valid_q & bus.out_ready;
  // While busy the next scan starts just past the current owner, which is where ptr lands on rotation.
  assign pick_ptr = (state == BUSY) ? sel_q + SEL_W'(1) : ptr;
  assign keep     = bus.req[sel_q] && (({1'b0, beat_cnt} + 1'b1) < BURST_C);

  rr_pick u_pick (
    .req (bus.req),
    .ptr (pick_ptr),
    .any (any),
    .idx (win)
  );

  mux8 u_mux (
    .a   (bus.a),
    .b   (bus.b),
    .c   (bus.c),
    .d   (bus.d),
    .e   (bus.e),
    .f   (bus.f),
    .g   (bus.g),
    .h   (bus.h),
    .sel (sel_q),
    .y   (bus.out_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      sel_q    <= '0;
      gnt_q    <= '0;
      valid_q  <= 1'b0;
      beat_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            sel_q    <= win;
            gnt_q    <= onehot(win);
            valid_q  <= 1'b1;
            beat_cnt <= '0;
            state    <= BUSY;
          end
        end
        BUSY: begin
          if (xfer) begin
            if (keep) begin
              beat_cnt <= beat_cnt + 1'b1;
            end else begin
              ptr <= pick_ptr;
              if (any) begin
                sel_q    <= win;
                gnt_q    <= onehot(win);
                beat_cnt <= '0;
              end else begin
                gnt_q   <= '0;
                valid_q <= 1'b0;
                state   <= IDLE;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sel       = sel_q;
  assign bus.gnt       = gnt_q;
  assign bus.out_valid = valid_q;
  assign bus.ack       = gnt_q & {N_REQ{xfer}};
  assign bus.busy      = (state != IDLE);
endmodule
